// File: rtl/rotate_request_queue.sv
// Buffered rotate front end: requests queue in a small register FIFO, are rotated
// one per cycle on pop, and the result is held in an output register under valid/ready.
module rotate_request_queue #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH),
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [AMT_W-1:0]         in_amount,
  input  logic                     in_dir,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_dir,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         done_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic             dir;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] data;
  } req_t;

  req_t             fifo [DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] cnt;
  logic             push, pop, free;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0] rot_l, rot_r, rot_res;

  // in_ready depends only on occupancy, so a same-cycle pop never frees a slot early
  assign in_ready = !rst && (cnt != LVL_W'(DEPTH));
  assign level    = cnt;
  assign push     = in_valid && in_ready;
  assign free     = !out_valid || out_ready;
  assign pop      = free && (cnt != '0);
  assign head     = fifo[rd_ptr];

  // Rotation via a doubled operand: the wrapped bits fall out of the shift naturally
  assign dbl     = {head.data, head.data};
  assign rot_l   = WIDTH'((dbl << head.amt) >> WIDTH);
  assign rot_r   = WIDTH'(dbl >> head.amt);
  assign rot_res = head.dir ? rot_r : rot_l;

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{dir: in_dir, amt: in_amount, data: in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + LVL_W'(1);
        2'b01:   cnt <= cnt - LVL_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_dir    <= 1'b0;
      done_count <= '0;
    end else begin
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= rot_res;
        out_dir   <= head.dir;
      end else if (free) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) done_count <= done_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/rotate_request_queue.md
Name: rotate_request_queue

Overview:
Buffered, handshaked front end for the team's parameterised left/right rotators. Accepts rotate requests (operand, amount, direction) over valid/ready and holds them in a small FIFO. Issues each request in order through an internal rotate datapath with the same semantics as those rotators, and presents registered results downstream over valid/ready. Sits between the request source and the result consumer so that rotation work can be absorbed under backpressure.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, >= 2
AMT_W, $clog2(WIDTH) (3), rotate amount width
DEPTH, 4, request FIFO entries; power of two, >= 2
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  request present
in_ready  out  1  FIFO can accept this cycle
in_data  in  WIDTH  operand
in_amount  in  AMT_W  rotate amount, 0..WIDTH-1
in_dir  in  1  0 = rotate left, 1 = rotate right
out_valid  out  1  result register holds a valid result
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  rotated result
out_dir  out  1  direction of the request that produced out_data
level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
done_count  out  CNT_W  number of results accepted downstream

Behaviour:
- Reset (async, active-high): FIFO empty, wr/rd pointers 0, level=0, out_valid=0, out_data=0, out_dir=0, done_count=0. in_ready=0 while rst is high, then 1.
- in_ready = (level != DEPTH). Push on in_valid && in_ready. No combinational path from out_ready to in_ready.
- Rotate semantics: left: result = (d << k) | (d >> (WIDTH-k)); right: mirror image; k=0 returns d unchanged. Amount is taken modulo WIDTH as given (AMT_W bits cover the full range).
- Output stage: the stage is "free" when out_valid=0 or (out_valid && out_ready).
  - If free and FIFO non-empty: at the clock edge pop the head, load out_data = rotate(head), load out_dir, set out_valid=1.
  - If free and FIFO empty: out_valid<=0.
  - Otherwise hold out_data, out_dir, and out_valid stable; they must not change while out_valid && !out_ready.
- Latency: a request accepted at edge N into an empty FIFO with a free output stage produces out_valid=1 after edge N+1. There is no FIFO bypass. Sustained throughput is 1 result/cycle when out_ready=1.
- Ordering: strictly FIFO. Pointers wrap modulo DEPTH.
- Simultaneous push and pop in the same cycle: level is unchanged. This is legal at every level except full (no push) and empty (no pop).
- Full: in_ready=0 and in_valid is ignored. A pop in that same cycle does not enable a push until the next cycle.
- Empty with out_valid && !out_ready: hold.
- done_count increments on each out_valid && out_ready edge and wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-operation discards all queued and in-flight requests immediately. No partial result is emitted after reset is released.
- Implementation is fully synchronous apart from the async reset. The FIFO is register-based; no memory macros.

Test Plan:
- Reset release, out_ready=1: push (0x66, 5, L), (0x66, 5, R), (0x23, 7, L), (0x23, 7, R), (0xC7, 2, L), (0xC7, 2, R) back-to-back. Required: out_data sequence 0xCC, 0x33, 0x91, 0x46, 0x1F, 0xF1 in order; first out_valid one cycle after the first accept; done_count=6.
- Amount 0: push (0xA5, 0, L) then (0xA5, 0, R) -> 0xA5, 0xA5.
- Backpressure/full: out_ready=0, push 6 requests. Required: first result loaded into the output register; level reaches 4; in_ready=0 with level=4; out_data stays stable. Raise out_ready: all 5 results drain in order, in_ready returns high one cycle after the first pop.
- Simultaneous push/pop: with level=2 and out_ready=1, push every cycle for 8 cycles. Required: level stays 2, ordering preserved, pointers wrap correctly.
- Reset mid-stream: with level=3 and out_valid=1, assert rst for 1 cycle. Required: out_valid=0, level=0, done_count=0 immediately; no stale result appears after release.
- Counter wrap (CNT_W=4 override): complete 17 handshakes -> done_count=1.
